// File: rtl/csr_pkg.sv
// Shared CSR address map, mstatus/mepc masks and write-port helpers for csr_reg.
// CSR_INSTRET_EN adds the minstret addresses to the writable set.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;
  localparam logic [31:0] MEPC_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  function automatic logic csr_writable(input logic [11:0] addr);
    logic ok;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH: ok = 1'b1;
`ifdef CSR_INSTRET_EN
      CSR_MINSTRET, CSR_MINSTRETH:                  ok = 1'b1;
`endif
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] csr_wr_mask(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] res;
    case (addr)
      CSR_MSTATUS: res = data & MSTATUS_WMASK;
      CSR_MEPC:    res = data & MEPC_ALIGN_MASK;
      default:     res = data;
    endcase
    return res;
  endfunction

  // {hit, data}: the interrupt port wins when both ports target addr.
  function automatic logic [32:0] csr_pick(input csr_wr_t int_w, input csr_wr_t ex_w,
                                           input logic [11:0] addr);
    logic [32:0] res;
    if (int_w.en && (int_w.addr == addr)) begin
      res = {1'b1, int_w.data};
    end else if (ex_w.en && (ex_w.addr == addr)) begin
      res = {1'b1, ex_w.data};
    end else begin
      res = 33'h0;
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_reg_if.sv
// CSR read port plus the execute-stage and interrupt-controller write ports.
interface csr_reg_if;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        ex_wr_en_i;
  logic [31:0] ex_wr_addr_i;
  logic [31:0] ex_wr_data_i;
  logic        int_wr_en_i;
  logic [31:0] int_wr_addr_i;
  logic [31:0] int_wr_data_i;

  modport master (
    output rd_addr_i, ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i,
    output int_wr_en_i, int_wr_addr_i, int_wr_data_i,
    input  rd_data_o
  );

  modport slave (
    input  rd_addr_i, ex_wr_en_i, ex_wr_addr_i, ex_wr_data_i,
    input  int_wr_en_i, int_wr_addr_i, int_wr_data_i,
    output rd_data_o
  );
endinterface

// File: rtl/csr_counter64.sv
// Enable-gated 64-bit counter with independent low/high word writes.
module csr_counter64 #(
  parameter logic [63:0] RST_VAL = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo_en,
  input  logic [31:0] wr_lo_data,
  input  logic        wr_hi_en,
  input  logic [31:0] wr_hi_data,
  output logic [63:0] cnt_o
);
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_nxt_s;
  logic [31:0] hi_nxt_s;
  logic        carry_s;

  // Next-state: a low write suppresses the carry, a high write discards it.
  always_comb begin
    carry_s = inc_en && (lo_r == 32'hFFFF_FFFF);
    if (wr_lo_en) begin
      lo_nxt_s = wr_lo_data;
    end else if (inc_en) begin
      lo_nxt_s = lo_r + 32'd1;
    end else begin
      lo_nxt_s = lo_r;
    end
    if (wr_hi_en) begin
      hi_nxt_s = wr_hi_data;
    end else if (carry_s && !wr_lo_en) begin
      hi_nxt_s = hi_r + 32'd1;
    end else begin
      hi_nxt_s = hi_r;
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_r <= RST_VAL[31:0];
      hi_r <= RST_VAL[63:32];
    end else begin
      lo_r <= lo_nxt_s;
      hi_r <= hi_nxt_s;
    end
  end

  assign cnt_o = {hi_r, lo_r};
endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file with cycle counter and write-through read bypass.
// CSR_INSTRET_EN adds minstret (0xB02/0xB82, aliases 0xC02/0xC82).
module csr_reg
  import csr_pkg::*;
#(
  parameter logic [63:0] CYCLE_RST_VAL = 64'h0,
  parameter logic [31:0] MTVEC_RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_reg_if.slave    bus,
  input  logic        instret_inc_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic        global_int_en_o
);
  csr_wr_t     ex_wr_s;
  csr_wr_t     int_wr_s;
  logic [32:0] mstatus_wr_s, mie_wr_s, mtvec_wr_s, mscratch_wr_s;
  logic [32:0] mepc_wr_s, mcause_wr_s, mcycle_lo_wr_s, mcycle_hi_wr_s;
  logic [31:0] mstatus_r, mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;
  logic [11:0] rd_addr_s;
  logic [32:0] rd_pick_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  // Write ports pre-filtered to writable addresses and pre-masked.
  always_comb begin
    ex_wr_s.en    = bus.ex_wr_en_i && csr_writable(bus.ex_wr_addr_i[11:0]);
    ex_wr_s.addr  = bus.ex_wr_addr_i[11:0];
    ex_wr_s.data  = csr_wr_mask(bus.ex_wr_addr_i[11:0], bus.ex_wr_data_i);
    int_wr_s.en   = bus.int_wr_en_i && csr_writable(bus.int_wr_addr_i[11:0]);
    int_wr_s.addr = bus.int_wr_addr_i[11:0];
    int_wr_s.data = csr_wr_mask(bus.int_wr_addr_i[11:0], bus.int_wr_data_i);
  end

  assign mstatus_wr_s   = csr_pick(int_wr_s, ex_wr_s, CSR_MSTATUS);
  assign mie_wr_s       = csr_pick(int_wr_s, ex_wr_s, CSR_MIE);
  assign mtvec_wr_s     = csr_pick(int_wr_s, ex_wr_s, CSR_MTVEC);
  assign mscratch_wr_s  = csr_pick(int_wr_s, ex_wr_s, CSR_MSCRATCH);
  assign mepc_wr_s      = csr_pick(int_wr_s, ex_wr_s, CSR_MEPC);
  assign mcause_wr_s    = csr_pick(int_wr_s, ex_wr_s, CSR_MCAUSE);
  assign mcycle_lo_wr_s = csr_pick(int_wr_s, ex_wr_s, CSR_MCYCLE);
  assign mcycle_hi_wr_s = csr_pick(int_wr_s, ex_wr_s, CSR_MCYCLEH);

  // Plain machine-mode registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_r  <= 32'h0;
      mie_r      <= 32'h0;
      mtvec_r    <= MTVEC_RST_VAL;
      mscratch_r <= 32'h0;
      mepc_r     <= 32'h0;
      mcause_r   <= 32'h0;
    end else begin
      if (mstatus_wr_s[32])  mstatus_r  <= mstatus_wr_s[31:0];
      if (mie_wr_s[32])      mie_r      <= mie_wr_s[31:0];
      if (mtvec_wr_s[32])    mtvec_r    <= mtvec_wr_s[31:0];
      if (mscratch_wr_s[32]) mscratch_r <= mscratch_wr_s[31:0];
      if (mepc_wr_s[32])     mepc_r     <= mepc_wr_s[31:0];
      if (mcause_wr_s[32])   mcause_r   <= mcause_wr_s[31:0];
    end
  end

  csr_counter64 #(.RST_VAL(CYCLE_RST_VAL)) u_mcycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en     (1'b1),
    .wr_lo_en   (mcycle_lo_wr_s[32]),
    .wr_lo_data (mcycle_lo_wr_s[31:0]),
    .wr_hi_en   (mcycle_hi_wr_s[32]),
    .wr_hi_data (mcycle_hi_wr_s[31:0]),
    .cnt_o      (mcycle_s)
  );

`ifdef CSR_INSTRET_EN
  logic [32:0] minstret_lo_wr_s, minstret_hi_wr_s;
  assign minstret_lo_wr_s = csr_pick(int_wr_s, ex_wr_s, CSR_MINSTRET);
  assign minstret_hi_wr_s = csr_pick(int_wr_s, ex_wr_s, CSR_MINSTRETH);

  csr_counter64 #(.RST_VAL(64'h0)) u_minstret (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en     (instret_inc_i),
    .wr_lo_en   (minstret_lo_wr_s[32]),
    .wr_lo_data (minstret_lo_wr_s[31:0]),
    .wr_hi_en   (minstret_hi_wr_s[32]),
    .wr_hi_data (minstret_hi_wr_s[31:0]),
    .cnt_o      (minstret_s)
  );
  assign unused_s = ^{bus.rd_addr_i[31:12], bus.ex_wr_addr_i[31:12], bus.int_wr_addr_i[31:12]};
`else
  assign minstret_s = 64'h0;
  assign unused_s   = ^{instret_inc_i, bus.rd_addr_i[31:12], bus.ex_wr_addr_i[31:12],
                        bus.int_wr_addr_i[31:12]};
`endif

  // Read mux: a pending write to the read address is forwarded.
  always_comb begin
    rd_addr_s = bus.rd_addr_i[11:0];
    rd_pick_s = csr_pick(int_wr_s, ex_wr_s, rd_addr_s);
    if (rd_pick_s[32]) begin
      rd_data_s = rd_pick_s[31:0];
    end else begin
      case (rd_addr_s)
        CSR_MSTATUS:                 rd_data_s = mstatus_r;
        CSR_MIE:                     rd_data_s = mie_r;
        CSR_MTVEC:                   rd_data_s = mtvec_r;
        CSR_MSCRATCH:                rd_data_s = mscratch_r;
        CSR_MEPC:                    rd_data_s = mepc_r;
        CSR_MCAUSE:                  rd_data_s = mcause_r;
        CSR_MCYCLE, CSR_CYCLE:       rd_data_s = mcycle_s[31:0];
        CSR_MCYCLEH, CSR_CYCLEH:     rd_data_s = mcycle_s[63:32];
        CSR_MINSTRET, CSR_INSTRET:   rd_data_s = minstret_s[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: rd_data_s = minstret_s[63:32];
        default:                     rd_data_s = 32'h0;
      endcase
    end
  end

  assign bus.rd_data_o   = rd_data_s;
  assign mtvec_o         = mtvec_r;
  assign mepc_o          = mepc_r;
  assign mstatus_o       = mstatus_r;
  assign mie_o           = mie_r;
  assign global_int_en_o = mstatus_r[MSTATUS_MIE_BIT];
endmodule

// File: tb/tb_csr_reg.sv
// Self-checking bench for csr_reg: directed scenarios plus randomized traffic against a model.
module tb_csr_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instret_inc = 1'b0;
  logic [31:0] mtvec, mepc, mstatus, mie;
  logic        gie;
  int          checks = 0;
  int          failures = 0;

  // Model state
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;
  logic [11:0] addr_tbl [16];

  csr_reg_if bus ();

  csr_reg #(.CYCLE_RST_VAL(64'h0), .MTVEC_RST_VAL(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .instret_inc_i   (instret_inc),
    .mtvec_o         (mtvec),
    .mepc_o          (mepc),
    .mstatus_o       (mstatus),
    .mie_o           (mie),
    .global_int_en_o (gie)
  );

  always #5 clk = ~clk;

  function automatic bit m_writable(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80: return 1'b1;
`ifdef CSR_INSTRET_EN
      12'hB02, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_mask(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h300) return d & 32'h0000_0088;
    if (a == 12'h341) return {d[31:2], 2'b00};
    return d;
  endfunction

  function automatic logic [31:0] m_stored(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
`ifdef CSR_INSTRET_EN
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (bus.int_wr_en_i && bus.int_wr_addr_i[11:0] == a && m_writable(a))
      return m_mask(a, bus.int_wr_data_i);
    if (bus.ex_wr_en_i && bus.ex_wr_addr_i[11:0] == a && m_writable(a))
      return m_mask(a, bus.ex_wr_data_i);
    return m_stored(a);
  endfunction

  // Advance the model by one clock from the inputs currently applied.
  task automatic model_update();
    logic [31:0] pend [int];
    logic [63:0] nc, ni;
    if (!rst_n) begin
      m_mstatus = 32'h0; m_mie = 32'h0; m_mtvec = 32'h0; m_mscratch = 32'h0;
      m_mepc = 32'h0; m_mcause = 32'h0; m_cycle = 64'h0; m_instret = 64'h0;
      return;
    end
    if (bus.ex_wr_en_i && m_writable(bus.ex_wr_addr_i[11:0]))
      pend[int'(bus.ex_wr_addr_i[11:0])] = m_mask(bus.ex_wr_addr_i[11:0], bus.ex_wr_data_i);
    if (bus.int_wr_en_i && m_writable(bus.int_wr_addr_i[11:0]))
      pend[int'(bus.int_wr_addr_i[11:0])] = m_mask(bus.int_wr_addr_i[11:0], bus.int_wr_data_i);
    nc = m_cycle + 64'd1;
    ni = m_instret + (instret_inc ? 64'd1 : 64'd0);
    if (pend.exists(32'hB00)) nc = {m_cycle[63:32], pend[32'hB00]};
    if (pend.exists(32'hB80)) nc[63:32] = pend[32'hB80];
    if (pend.exists(32'hB02)) ni = {m_instret[63:32], pend[32'hB02]};
    if (pend.exists(32'hB82)) ni[63:32] = pend[32'hB82];
    if (pend.exists(32'h300)) m_mstatus  = pend[32'h300];
    if (pend.exists(32'h304)) m_mie      = pend[32'h304];
    if (pend.exists(32'h305)) m_mtvec    = pend[32'h305];
    if (pend.exists(32'h340)) m_mscratch = pend[32'h340];
    if (pend.exists(32'h341)) m_mepc     = pend[32'h341];
    if (pend.exists(32'h342)) m_mcause   = pend[32'h342];
    m_cycle = nc;
`ifdef CSR_INSTRET_EN
    m_instret = ni;
`else
    m_instret = 64'h0;
`endif
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic en, input logic [31:0] a, input logic [31:0] d);
    bus.ex_wr_en_i = en; bus.ex_wr_addr_i = a; bus.ex_wr_data_i = d;
  endtask

  task automatic set_int(input logic en, input logic [31:0] a, input logic [31:0] d);
    bus.int_wr_en_i = en; bus.int_wr_addr_i = a; bus.int_wr_data_i = d;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0; instret_inc = 1'b1;
    set_ex(1'b1, 32'h300, 32'hFFFF_FFFF);
    set_int(1'b1, 32'h305, 32'h0000_1234);
    repeat (3) tick();
    rst_n = 1'b1; instret_inc = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0);
    set_int(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_i = {20'h0, addr_tbl[i]};
      #1;
      exp = 32'h0;
      checks++;
      if (bus.rd_data_o !== exp) begin
        failures++;
        $display("FAIL reset_read addr=%h actual=%h expected=%h", addr_tbl[i], bus.rd_data_o, exp);
      end
    end
    checks++;
    if ({mtvec, mepc, mstatus, mie, gie} !== {128'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mirrors actual=%h %h %h %h %b expected=0", mtvec, mepc, mstatus, mie, gie);
    end
  endtask

  task automatic test_mstatus_mask();
    set_ex(1'b1, 32'h300, 32'hFFFF_FFFF);
    bus.rd_addr_i = 32'h300;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h88) begin
      failures++;
      $display("FAIL mstatus_bypass actual=%h expected=00000088", bus.rd_data_o);
    end
    tick();
    set_ex(1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h88 || mstatus !== 32'h88 || gie !== 1'b1) begin
      failures++;
      $display("FAIL mstatus_stored actual=%h/%h gie=%b expected=00000088 gie=1",
               bus.rd_data_o, mstatus, gie);
    end
  endtask

  task automatic test_collision();
    set_int(1'b1, 32'h341, 32'h100);
    set_ex(1'b1, 32'h341, 32'h200);
    bus.rd_addr_i = 32'h341;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h100) begin
      failures++;
      $display("FAIL collision_bypass actual=%h expected=00000100", bus.rd_data_o);
    end
    tick();
    set_int(1'b0, 32'h0, 32'h0);
    set_ex(1'b1, 32'h341, 32'h203);
    #1;
    checks++;
    if (mepc !== 32'h100) begin
      failures++;
      $display("FAIL collision_mepc actual=%h expected=00000100", mepc);
    end
    tick();
    set_ex(1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (mepc !== 32'h200 || bus.rd_data_o !== 32'h200) begin
      failures++;
      $display("FAIL mepc_align actual=%h/%h expected=00000200", mepc, bus.rd_data_o);
    end
  endtask

  task automatic test_cycle_wrap();
    set_ex(1'b1, 32'hB80, 32'hFFFF_FFFF);
    tick();
    set_ex(1'b1, 32'hB00, 32'hFFFF_FFFE);
    tick();
    set_ex(1'b0, 32'h0, 32'h0);
    bus.rd_addr_i = 32'hC00;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL wrap_lo0 actual=%h expected=fffffffe", bus.rd_data_o);
    end
    tick();
    checks++;
    if (bus.rd_data_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_lo1 actual=%h expected=ffffffff", bus.rd_data_o);
    end
    bus.rd_addr_i = 32'hC80;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_hi1 actual=%h expected=ffffffff", bus.rd_data_o);
    end
    tick();
    checks++;
    if (bus.rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL wrap_hi2 actual=%h expected=00000000", bus.rd_data_o);
    end
    bus.rd_addr_i = 32'hC00;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL wrap_lo2 actual=%h expected=00000000", bus.rd_data_o);
    end
  endtask

  task automatic test_dropped_writes();
    logic [31:0] prev;
    set_ex(1'b1, 32'hC00, 32'h1234);
    bus.rd_addr_i = 32'hC00;
    #1;
    prev = bus.rd_data_o;
    checks++;
    if (prev !== m_cycle[31:0]) begin
      failures++;
      $display("FAIL ro_no_bypass actual=%h expected=%h", prev, m_cycle[31:0]);
    end
    tick();
    set_ex(1'b1, 32'h7C0, 32'h5);
    #1;
    checks++;
    if (bus.rd_data_o !== prev + 32'd1) begin
      failures++;
      $display("FAIL ro_drop actual=%h expected=%h", bus.rd_data_o, prev + 32'd1);
    end
    bus.rd_addr_i = 32'h7C0;
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL unimpl_bypass actual=%h expected=00000000", bus.rd_data_o);
    end
    tick();
    set_ex(1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.rd_data_o !== 32'h0) begin
      failures++;
      $display("FAIL unimpl_read actual=%h expected=00000000", bus.rd_data_o);
    end
  endtask

  task automatic test_instret();
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) begin
      instret_inc = (i % 2 == 0);
      tick();
    end
    instret_inc = 1'b0;
    bus.rd_addr_i = 32'hC02;
    #1;
`ifdef CSR_INSTRET_EN
    exp = 32'd5;
`else
    exp = 32'd0;
`endif
    checks++;
    if (bus.rd_data_o !== exp) begin
      failures++;
      $display("FAIL instret_count actual=%h expected=%h", bus.rd_data_o, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, exp;
    logic [11:0] ra;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      set_ex($urandom_range(0, 1) == 1, {r[31:12], addr_tbl[$urandom_range(0, 15)]}, $urandom());
      r = $urandom();
      set_int($urandom_range(0, 2) == 0, {r[31:12], addr_tbl[$urandom_range(0, 15)]}, $urandom());
      if ($urandom_range(0, 3) == 0) bus.int_wr_addr_i[11:0] = bus.ex_wr_addr_i[11:0];
      instret_inc = $urandom_range(0, 1) == 1;
      r = $urandom();
      case ($urandom_range(0, 3))
        0: ra = bus.ex_wr_addr_i[11:0];
        1: ra = bus.int_wr_addr_i[11:0];
        default: ra = addr_tbl[$urandom_range(0, 15)];
      endcase
      bus.rd_addr_i = {r[31:12], ra};
      #1;
      exp = exp_read(ra);
      checks++;
      if (bus.rd_data_o !== exp) begin
        failures++;
        $display("FAIL rand_read n=%0d addr=%h actual=%h expected=%h", n, ra, bus.rd_data_o, exp);
      end
      tick();
      checks++;
      if ({mtvec, mepc, mstatus, mie, gie} !== {m_mtvec, m_mepc, m_mstatus, m_mie, m_mstatus[3]}) begin
        failures++;
        $display("FAIL rand_mirrors n=%0d actual=%h %h %h %h %b expected=%h %h %h %h %b", n,
                 mtvec, mepc, mstatus, mie, gie, m_mtvec, m_mepc, m_mstatus, m_mie, m_mstatus[3]);
      end
    end
    set_ex(1'b0, 32'h0, 32'h0);
    set_int(1'b0, 32'h0, 32'h0);
    instret_inc = 1'b0;
  endtask

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                 12'hC00, 12'hC80, 12'hB02, 12'hB82, 12'hC02, 12'hC82, 12'h7C0, 12'hFFF};
    bus.rd_addr_i = 32'h0;
    set_ex(1'b0, 32'h0, 32'h0);
    set_int(1'b0, 32'h0, 32'h0);
    test_reset();
    test_mstatus_mask();
    test_collision();
    test_cycle_wrap();
    test_dropped_writes();
    test_instret();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
